// File: rtl/lagarto_pmu_counter_bank.sv
// Programmable PMU counter bank: NUM_CNT counters, each counting one selectable event.
// Provides sticky overflow flags, an overflow interrupt, a post-reset wake-up hold and a register access port.
module lagarto_pmu_counter_bank #(
   parameter int NUM_EVENTS  = 23,
   parameter int NUM_CNT     = 4,
   parameter int CNT_W       = 48,
   parameter int WAKE_CYCLES = 32768
) (
   input  logic                  clk_i,
   input  logic                  reset_l,
   input  logic [NUM_EVENTS-1:0] events_i,
   input  logic                  req_i,
   input  logic                  we_i,
   input  logic [7:0]            addr_i,
   input  logic [63:0]           wdata_i,
   output logic [63:0]           rdata_o,
   output logic                  ack_o,
   output logic                  irq_o,
   output logic                  ready_o
);

   localparam int WAKE_W = $clog2(WAKE_CYCLES + 1);
   localparam logic [WAKE_W-1:0] WAKE_MAX = WAKE_W'(WAKE_CYCLES);

   typedef enum logic [1:0] {
      CLS_CNT = 2'd0,
      CLS_CFG = 2'd1,
      CLS_OVF = 2'd2,
      CLS_GLB = 2'd3
   } reg_class_e;

   logic [WAKE_W-1:0]  wake_reg;
   logic [CNT_W-1:0]   cnt_reg [NUM_CNT];
   logic [7:0]         sel_reg [NUM_CNT];
   logic [NUM_CNT-1:0] en_reg;
   logic [NUM_CNT-1:0] ie_reg;
   logic [NUM_CNT-1:0] frz_reg;
   logic [NUM_CNT-1:0] ovf_reg;
   logic               gen_reg;
   logic               ack_reg;
   logic [63:0]        rdata_reg;
   logic [63:0]        rdata_next;

   reg_class_e         cls;
   logic [5:0]         idx;
   logic               wr;
   logic               clear_all;
   logic               ovf_w1c;
   logic [255:0]       ev_pad;
   logic [NUM_CNT-1:0] hit;
   logic [NUM_CNT-1:0] cnt_wr;
   logic [NUM_CNT-1:0] cfg_wr;
   logic [NUM_CNT-1:0] inc;
   logic [NUM_CNT-1:0] ovf_set;
   logic               unused_wdata;

   assign cls       = reg_class_e'(addr_i[7:6]);
   assign idx       = addr_i[5:0];
   assign wr        = req_i & we_i;
   assign clear_all = wr && (cls == CLS_GLB) && wdata_i[1];
   assign ovf_w1c   = wr && (cls == CLS_OVF);
   // Zero padding makes any sel >= NUM_EVENTS select a constant 0, so it never counts.
   assign ev_pad    = 256'(events_i);
   assign unused_wdata = ^wdata_i;

   assign ready_o = (wake_reg == WAKE_MAX);
   assign irq_o   = |(ovf_reg & ie_reg);
   assign ack_o   = ack_reg;
   assign rdata_o = rdata_reg;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
         assign hit[gi]    = (idx == 6'(gi));
         assign cnt_wr[gi] = wr && (cls == CLS_CNT) && hit[gi];
         assign cfg_wr[gi] = wr && (cls == CLS_CFG) && hit[gi];
         assign inc[gi]    = ready_o & gen_reg & en_reg[gi] & ev_pad[sel_reg[gi]]
                             & ~(frz_reg[gi] & ovf_reg[gi]);
         // A same-cycle counter write suppresses the increment and therefore its overflow.
         assign ovf_set[gi] = inc[gi] & ~cnt_wr[gi] & (&cnt_reg[gi]);
      end
   endgenerate

   always_ff @(posedge clk_i or negedge reset_l) begin
      if (!reset_l) begin
         wake_reg <= '0;
      end else if (wake_reg != WAKE_MAX) begin
         wake_reg <= wake_reg + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge reset_l) begin
      if (!reset_l) begin
         for (int i = 0; i < NUM_CNT; i++) begin
            cnt_reg[i] <= '0;
            sel_reg[i] <= '0;
         end
         en_reg  <= '0;
         ie_reg  <= '0;
         frz_reg <= '0;
         ovf_reg <= '0;
         gen_reg <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CNT; i++) begin
            if (clear_all) begin
               cnt_reg[i] <= '0;
               ovf_reg[i] <= 1'b0;
            end else begin
               if (cnt_wr[i]) begin
                  cnt_reg[i] <= wdata_i[CNT_W-1:0];
               end else if (inc[i]) begin
                  cnt_reg[i] <= cnt_reg[i] + 1'b1;
               end
               ovf_reg[i] <= (ovf_reg[i] & ~(ovf_w1c & wdata_i[i])) | ovf_set[i];
            end
            if (cfg_wr[i]) begin
               sel_reg[i] <= wdata_i[7:0];
               en_reg[i]  <= wdata_i[8];
               ie_reg[i]  <= wdata_i[9];
               frz_reg[i] <= wdata_i[10];
            end
         end
         if (wr && (cls == CLS_GLB)) begin
            gen_reg <= wdata_i[0];
         end
      end
   end

   // Read data samples state before this cycle's updates.
   always_comb begin
      rdata_next = '0;
      if (req_i && !we_i) begin
         case (cls)
            CLS_CNT: begin
               for (int i = 0; i < NUM_CNT; i++) begin
                  if (hit[i]) rdata_next = 64'(cnt_reg[i]);
               end
            end
            CLS_CFG: begin
               for (int i = 0; i < NUM_CNT; i++) begin
                  if (hit[i]) rdata_next = {53'b0, frz_reg[i], ie_reg[i], en_reg[i], sel_reg[i]};
               end
            end
            CLS_OVF: rdata_next = 64'(ovf_reg);
            default: rdata_next = {63'b0, gen_reg};
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge reset_l) begin
      if (!reset_l) begin
         ack_reg   <= 1'b0;
         rdata_reg <= '0;
      end else begin
         ack_reg   <= req_i;
         rdata_reg <= rdata_next;
      end
   end

endmodule

// File: tb/tb_lagarto_pmu_counter_bank.sv
// Bench for lagarto_pmu_counter_bank: directed scenarios plus random traffic,
// checked every cycle against an arithmetic model of the counter bank.
module tb_lagarto_pmu_counter_bank;

   localparam int NE   = 23;
   localparam int NC   = 4;
   localparam int CW   = 8;
   localparam int WK   = 16;
   localparam int CMOD = 1 << CW;

   logic          clk = 1'b0;
   logic          reset_l = 1'b0;
   logic [NE-1:0] events = '0;
   logic          req = 1'b0;
   logic          we = 1'b0;
   logic [7:0]    addr = '0;
   logic [63:0]   wdata = '0;
   logic [63:0]   rdata;
   logic          ack;
   logic          irq;
   logic          ready;

   int checks = 0;
   int failures = 0;

   int m_cnt [NC];
   int m_sel [NC];
   bit m_en  [NC];
   bit m_ie  [NC];
   bit m_frz [NC];
   bit m_ovf [NC];
   bit m_gen;
   int m_wake;

   lagarto_pmu_counter_bank #(
      .NUM_EVENTS(NE), .NUM_CNT(NC), .CNT_W(CW), .WAKE_CYCLES(WK)
   ) dut (
      .clk_i(clk), .reset_l(reset_l), .events_i(events), .req_i(req), .we_i(we),
      .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata), .ack_o(ack), .irq_o(irq),
      .ready_o(ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NC; i++) begin
         m_cnt[i] = 0; m_sel[i] = 0; m_en[i] = 0; m_ie[i] = 0; m_frz[i] = 0; m_ovf[i] = 0;
      end
      m_gen  = 0;
      m_wake = 0;
   endtask

   function automatic bit model_irq();
      bit r = 0;
      for (int i = 0; i < NC; i++) r |= m_ovf[i] & m_ie[i];
      return r;
   endfunction

   // One clock: predict from the current inputs, advance, compare outputs #1 after the edge.
   task automatic cycle(input string tag);
      logic [63:0] exp_rd;
      bit          exp_ack;
      int          idx, cls;
      bit          inc [NC];
      exp_rd  = '0;
      exp_ack = req;
      idx     = int'(addr[5:0]);
      cls     = int'(addr[7:6]);
      if (req && !we) begin
         if (cls == 0 && idx < NC) exp_rd = 64'(m_cnt[idx]);
         else if (cls == 1 && idx < NC)
            exp_rd = 64'(m_sel[idx] + 256 * m_en[idx] + 512 * m_ie[idx] + 1024 * m_frz[idx]);
         else if (cls == 2) begin
            for (int i = 0; i < NC; i++) exp_rd[i] = m_ovf[i];
         end else if (cls == 3) exp_rd = 64'(m_gen);
      end
      for (int i = 0; i < NC; i++)
         inc[i] = (m_wake >= WK) && m_gen && m_en[i] && (m_sel[i] < NE) && events[m_sel[i]]
                  && !(m_frz[i] && m_ovf[i]);
      for (int i = 0; i < NC; i++) begin
         bit wrapped = 0;
         if (req && we && cls == 0 && idx == i) m_cnt[i] = int'(wdata[CW-1:0]);
         else if (inc[i]) begin
            m_cnt[i] = (m_cnt[i] + 1) % CMOD;
            wrapped = (m_cnt[i] == 0);
         end
         if (req && we && cls == 2 && wdata[i]) m_ovf[i] = 0;
         if (wrapped) m_ovf[i] = 1;
         if (req && we && cls == 1 && idx == i) begin
            m_sel[i] = int'(wdata[7:0]);
            m_en[i] = wdata[8]; m_ie[i] = wdata[9]; m_frz[i] = wdata[10];
         end
      end
      if (req && we && cls == 3) begin
         m_gen = wdata[0];
         if (wdata[1]) for (int i = 0; i < NC; i++) begin m_cnt[i] = 0; m_ovf[i] = 0; end
      end
      if (m_wake < WK) m_wake++;
      @(posedge clk);
      #1;
      check($sformatf("%s.ack", tag), 64'(ack), 64'(exp_ack));
      check($sformatf("%s.rdata", tag), rdata, exp_rd);
      check($sformatf("%s.irq", tag), 64'(irq), 64'(model_irq()));
      check($sformatf("%s.ready", tag), 64'(ready), 64'(m_wake >= WK));
   endtask

   task automatic access(input bit w, input logic [7:0] a, input logic [63:0] d, input string tag);
      req = 1'b1; we = w; addr = a; wdata = d;
      cycle(tag);
      req = 1'b0; we = 1'b0;
   endtask

   task automatic idle(input int n, input string tag);
      repeat (n) cycle(tag);
   endtask

   initial begin
      model_reset();
      #1;
      check("rst.ack", 64'(ack), 64'd0);
      check("rst.rdata", rdata, 64'd0);
      check("rst.irq", 64'(irq), 64'd0);
      check("rst.ready", 64'(ready), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      reset_l = 1'b1;

      // Wake-up hold: enabled counter with active event must stay at 0.
      events[0] = 1'b1;
      access(1, 8'hC0, 64'h1, "wake_gen");
      access(1, 8'h40, 64'h100, "wake_cfg0");
      idle(10, "wake");
      access(0, 8'h00, 64'h0, "wake_rd0");
      check("wake.cnt0_zero", rdata, 64'd0);
      idle(6, "wake_end");

      // Basic count of event 5 for ten cycles.
      events = '0;
      access(1, 8'h40, 64'h105, "basic_cfg");
      access(1, 8'h00, 64'h0, "basic_clr");
      events[5] = 1'b1;
      idle(10, "basic_ev");
      events = '0;
      access(0, 8'h00, 64'h0, "basic_rd");
      check("basic.val", rdata, 64'd10);

      // Wrap of an 8-bit counter with overflow interrupt.
      access(1, 8'h01, 64'hFE, "wrap_wr");
      access(1, 8'h41, 64'h300, "wrap_cfg");
      events[0] = 1'b1;
      idle(3, "wrap_ev");
      events = '0;
      access(0, 8'h01, 64'h0, "wrap_rd");
      check("wrap.val", rdata, 64'h1);
      access(0, 8'h80, 64'h0, "wrap_ovf");
      check("wrap.ovf", rdata, 64'h2);
      check("wrap.irq", 64'(irq), 64'd1);
      access(1, 8'h80, 64'h2, "wrap_w1c");
      check("wrap.irq_clr", 64'(irq), 64'd0);

      // Freeze on overflow.
      access(1, 8'h02, 64'hFF, "frz_wr");
      access(1, 8'h42, 64'h501, "frz_cfg");
      events[1] = 1'b1;
      idle(4, "frz_ev");
      access(0, 8'h02, 64'h0, "frz_rd");
      check("frz.held", rdata, 64'h0);
      events = '0;
      access(0, 8'h80, 64'h0, "frz_ovf");
      check("frz.ovf", rdata, 64'h4);

      // Counter write colliding with an increment.
      access(1, 8'h43, 64'h102, "col_cfg");
      events[2] = 1'b1;
      idle(2, "col_ev");
      access(1, 8'h03, 64'h55, "col_wr");
      access(0, 8'h03, 64'h0, "col_rd");
      check("col.written", rdata, 64'h55);
      events = '0;

      // W1C colliding with a fresh overflow: set wins.
      access(1, 8'h01, 64'hFF, "w1c_wr");
      events[0] = 1'b1;
      access(1, 8'h80, 64'h2, "w1c_clr");
      events = '0;
      access(0, 8'h80, 64'h0, "w1c_rd");
      check("w1c.set_wins", 64'(rdata[1]), 64'd1);

      // Out-of-range index.
      access(0, 8'h3F, 64'h0, "oor_rd");
      check("oor.rd_zero", rdata, 64'h0);
      access(1, 8'h3F, 64'hAA, "oor_wr");
      for (int i = 0; i < NC; i++) access(0, 8'(i), 64'h0, "oor_chk");

      // Global clear_all keeps cfg and global_en.
      access(1, 8'hC0, 64'h3, "clr_wr");
      access(0, 8'hC0, 64'h0, "clr_gen");
      check("clr.gen_kept", rdata, 64'h1);
      access(0, 8'h41, 64'h0, "clr_cfg1");
      check("clr.cfg_kept", rdata, 64'h300);
      access(0, 8'h80, 64'h0, "clr_ovf");
      check("clr.ovf_zero", rdata, 64'h0);
      access(0, 8'h02, 64'h0, "clr_cnt2");
      check("clr.cnt_zero", rdata, 64'h0);

      // Random traffic against the model.
      for (int n = 0; n < 600; n++) begin
         events = NE'($urandom);
         if ($urandom_range(1, 0) == 1) begin
            int cls, pick;
            logic [5:0]  ix;
            logic [63:0] d;
            cls  = int'($urandom_range(3, 0));
            pick = int'($urandom_range(4, 0));
            ix   = (pick == 4) ? 6'd63 : 6'(pick);
            d    = {$urandom, $urandom};
            if (cls == 0 && $urandom_range(1, 0) == 1) d = 64'($urandom_range(255, 240));
            if (cls == 1) d = 64'($urandom_range(31, 0)) | (64'($urandom_range(7, 0)) << 8);
            if (cls == 3) d = {62'b0, ($urandom_range(7, 0) == 0), ($urandom_range(3, 0) != 0)};
            access($urandom_range(1, 0) == 1, {2'(cls), ix}, d, "rand");
         end else begin
            cycle("rand_idle");
         end
      end
      events = '0;

      // Asynchronous reset while an ack is being driven.
      access(1, 8'hC0, 64'h1, "ar_gen");
      access(1, 8'h41, 64'h300, "ar_cfg");
      access(1, 8'h01, 64'hFF, "ar_wr");
      events[0] = 1'b1;
      idle(1, "ar_ev");
      events = '0;
      check("ar.irq_pre", 64'(irq), 64'd1);
      access(0, 8'h00, 64'h0, "ar_req");
      reset_l = 1'b0;
      #1;
      check("ar.ack", 64'(ack), 64'd0);
      check("ar.rdata", rdata, 64'd0);
      check("ar.irq", 64'(irq), 64'd0);
      check("ar.ready", 64'(ready), 64'd0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset_l = 1'b1;
      for (int i = 0; i < NC; i++) begin
         access(0, 8'(i), 64'h0, "post_cnt");
         check("post.cnt_zero", rdata, 64'h0);
         access(0, 8'h40 + 8'(i), 64'h0, "post_cfg");
         check("post.cfg_zero", rdata, 64'h0);
      end
      access(0, 8'h80, 64'h0, "post_ovf");
      access(0, 8'hC0, 64'h0, "post_gen");
      check("post.gen_zero", rdata, 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
